pwm_multi: RTL



---
 rtl/pwm_multi.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator. One period counter is shared by
// CHANNELS duty comparators. Period and duty values are double-buffered and
// take effect only at period boundaries.
// Optional feature macro: PWM_CENTER_ALIGNED_EN adds the `center` input and
// an up/down counting mode.
module pwm_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
`ifdef PWM_CENTER_ALIGNED_EN
  input  logic                center,
`endif
  input  logic [WIDTH-1:0]    period,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_ch,
  input  logic [WIDTH-1:0]    wr_duty,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    p_act_q, p_act_d;
  logic [WIDTH-1:0]    d_sh_q  [CHANNELS];
  logic [WIDTH-1:0]    d_sh_d  [CHANNELS];
  logic [WIDTH-1:0]    d_act_q [CHANNELS];
  logic [WIDTH-1:0]    d_act_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                ps_q, ps_d;
  logic                boundary;

`ifdef PWM_CENTER_ALIGNED_EN
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
  dir_e dir_q, dir_d;
  logic center_q, center_d;
`endif

  // Shadow duty writes; a channel index outside the array matches nothing.
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      d_sh_d[i] = d_sh_q[i];
      if (wr_en && (wr_ch == i[CW-1:0])) begin
        d_sh_d[i] = wr_duty;
      end
    end
  end

  // Counter / direction next state and boundary detection.
  always_comb begin
    cnt_d    = cnt_q;
    p_act_d  = p_act_q;
    d_act_d  = d_act_q;
    boundary = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
    dir_d    = dir_q;
    center_d = center_q;
`endif
    if (!enable) begin
      cnt_d   = '0;
      p_act_d = period;
      d_act_d = d_sh_q;
`ifdef PWM_CENTER_ALIGNED_EN
      dir_d    = DIR_UP;
      center_d = center;
`endif
    end else begin
`ifdef PWM_CENTER_ALIGNED_EN
      // Boundary is the step that would land on 0 entering UP; with P=1 that
      // step leaves UP directly, and P=0 falls through to edge behaviour.
      if (center_q && (p_act_q != '0)) begin
        unique case (dir_q)
          DIR_UP: begin
            if (cnt_q == p_act_q) begin
              if (p_act_q == WIDTH'(1)) begin
                boundary = 1'b1;
              end else begin
                cnt_d = cnt_q - WIDTH'(1);
                dir_d = DIR_DOWN;
              end
            end else begin
              cnt_d = cnt_q + WIDTH'(1);
            end
          end
          DIR_DOWN: begin
            if (cnt_q <= WIDTH'(1)) begin
              boundary = 1'b1;
            end else begin
              cnt_d = cnt_q - WIDTH'(1);
            end
          end
        endcase
      end else
`endif
      if (cnt_q == p_act_q) begin
        boundary = 1'b1;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end

      if (boundary) begin
        cnt_d   = '0;
        p_act_d = period;
        d_act_d = d_sh_q;
`ifdef PWM_CENTER_ALIGNED_EN
        dir_d    = DIR_UP;
        center_d = center;
`endif
      end
    end
  end

  // Output next state: compare per channel, boundary pulse, forced low when idle.
  always_comb begin
    pwm_d = '0;
    ps_d  = 1'b0;
    if (enable) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        pwm_d[i] = (cnt_q < d_act_q[i]);
      end
      ps_d = boundary;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      p_act_q  <= '0;
      d_sh_q   <= '{default: '0};
      d_act_q  <= '{default: '0};
      pwm_q    <= '0;
      ps_q     <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
      dir_q    <= DIR_UP;
      center_q <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      p_act_q  <= p_act_d;
      d_sh_q   <= d_sh_d;
      d_act_q  <= d_act_d;
      pwm_q    <= pwm_d;
      ps_q     <= ps_d;
`ifdef PWM_CENTER_ALIGNED_EN
      dir_q    <= dir_d;
      center_q <= center_d;
`endif
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;

endmodule
